// File: rtl/cpu_pkg.sv
// Shared CPU definitions: encodings and the fetch-stage state type.
package cpu_pkg;

  localparam logic [31:0] NOP_WORD   = 32'h0000_0000;
  localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    FS_RUN,
    FS_DRAIN,
    FS_HALTED
  } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// Pipeline register with load enable and a synchronous bubble load.
// A bubble takes priority over the enable so a squash always wins over a stall.
module if_id_reg
  import cpu_pkg::*;
#(
  parameter int unsigned DataW = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             en_i,
  input  logic             bubble_i,
  input  logic [DataW-1:0] instr_i,
  input  logic [DataW-1:0] pc_plus4_i,
  output logic [DataW-1:0] instr_o,
  output logic [DataW-1:0] pc_plus4_o,
  output logic             valid_o
);

  logic [DataW-1:0] instr_d, instr_q;
  logic [DataW-1:0] pc_plus4_d, pc_plus4_q;
  logic             valid_d, valid_q;

  always_comb begin
    instr_d    = instr_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    if (bubble_i) begin
      instr_d    = DataW'(NOP_WORD);
      pc_plus4_d = '0;
      valid_d    = 1'b0;
    end else if (en_i) begin
      instr_d    = instr_i;
      pc_plus4_d = pc_plus4_i;
      valid_d    = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      instr_q    <= '0;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      instr_q    <= instr_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
    end
  end

  assign instr_o    = instr_q;
  assign pc_plus4_o = pc_plus4_q;
  assign valid_o    = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, IF/ID register, stall/flush handling and halt drain.
// Fetching the halt word freezes the PC and feeds bubbles until the pipeline is empty.
module fetch_stage #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] HALT_INSTR   = cpu_pkg::HALT_INSTR,
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pc_enable,
  input  logic             instr_enable,
  input  logic             redirectE,
  input  logic [31:0]      targetE,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      instrD,
  output logic [31:0]      pc_plus4D,
  output logic             validD,
  output logic             flushD,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  import cpu_pkg::*;

  // The drain counter holds remaining bubbles minus one, so it halts on reaching zero.
  localparam logic [3:0] DrainLoad = 4'(DRAIN_CYCLES - 1);

  fetch_state_e     state_d, state_q;
  logic [31:0]      pc_d, pc_q;
  logic [3:0]       drain_d, drain_q;
  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_d, flush_cnt_q;
  logic             ifid_en;
  logic             ifid_bubble;
  logic [31:0]      pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drain_d     = drain_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    ifid_en     = 1'b0;
    ifid_bubble = 1'b0;
    unique case (state_q)
      FS_RUN: begin
        if (redirectE) begin
          // Stall inputs are ignored: the stalled ID instruction is squashed anyway.
          pc_d        = targetE;
          ifid_bubble = 1'b1;
          flush_cnt_d = flush_cnt_q + 1'b1;
        end else if (!pc_enable) begin
          stall_cnt_d = stall_cnt_q + 1'b1;
          ifid_en     = instr_enable;
        end else if (imem_rdata == HALT_INSTR) begin
          ifid_bubble = 1'b1;
          drain_d     = DrainLoad;
          state_d     = FS_DRAIN;
        end else begin
          pc_d    = pc_plus4;
          ifid_en = instr_enable;
        end
      end
      FS_DRAIN: begin
        ifid_bubble = 1'b1;
        if (redirectE) begin
          // An older branch still in flight overrides the halt.
          pc_d    = targetE;
          state_d = FS_RUN;
        end else if (drain_q == 4'd0) begin
          state_d = FS_HALTED;
        end else begin
          drain_d = drain_q - 4'd1;
        end
      end
      FS_HALTED: begin
      end
      default: state_d = FS_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FS_RUN;
      pc_q        <= RESET_PC;
      drain_q     <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drain_q     <= drain_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  if_id_reg #(
    .DataW(32)
  ) u_if_id_reg (
    .clk_i     (clk),
    .reset_i   (reset),
    .en_i      (ifid_en),
    .bubble_i  (ifid_bubble),
    .instr_i   (imem_rdata),
    .pc_plus4_i(pc_plus4),
    .instr_o   (instrD),
    .pc_plus4_o(pc_plus4D),
    .valid_o   (validD)
  );

  assign imem_addr = pc_q;
  assign flushD    = redirectE;
  assign halted    = (state_q == FS_HALTED);
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
